// File: rtl/add_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addshare_pkg
// Description : Shared widths, operand/sum types and the output-slot state
//               encoding for the add_share_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package addshare_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 9;
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0] operand_t;
    typedef logic [SUM_W-1:0]  sum_t;

    // Result register occupancy: EMPTY holds nothing, FULL holds a result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage : addshare_pkg
`default_nettype wire

// File: rtl/add_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : add_share_arbiter_if
// Description : Request-side valid/ready bundle and result-side bus of the
//               shared adder. The master drives requests and consumes results.
// Revision    : 1.0 - initial release
// ============================================================================
interface add_share_arbiter_if #(
    parameter int N_REQ = 4
);
    import addshare_pkg::*;

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    operand_t [N_REQ-1:0] req_x;
    operand_t [N_REQ-1:0] req_y;
    logic                 res_valid;
    logic                 res_ready;
    sum_t                 res_sum;
    logic [ID_W-1:0]      res_id;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_sum, res_id
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_sum, res_id
    );

endinterface : add_share_arbiter_if
`default_nettype wire

// File: rtl/add_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first requester at or after
//               the pointer (wrapping), only while enabled; the pointer moves
//               to one past the winner when a handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  wire                                          clk,
    input  wire                                          rst_n,
    input  wire  [N_REQ-1:0]                             i_req,
    input  wire                                          i_enable,
    input  wire                                          i_advance,
    output logic [N_REQ-1:0]                             o_grant,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_grant_idx
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_wide;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_wide      = '0;
        w_idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_wide = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_wide >= (ID_W+1)'(N_REQ)) begin
                w_wide = w_wide - (ID_W+1)'(N_REQ);
            end
            w_idx = w_wide[ID_W-1:0];
            if (!w_found && i_enable && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                w_found        = 1'b1;
            end
        end
    end

    // Pointer advances past the winner only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == ID_W'(N_REQ-1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder89.sv
`default_nettype none
// ============================================================================
// Module      : adder89
// Description : 8-bit + 8-bit unsigned adder with 9-bit {carry, sum} result.
// Revision    : 1.0 - initial release
// ============================================================================
module adder89
    import addshare_pkg::*;
(
    input  operand_t i_a,
    input  operand_t i_b,
    output sum_t     o_sum
);

    // Zero-extend both operands so the carry lands in the MSB.
    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule : adder89
`default_nettype wire

// File: rtl/add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_share_arbiter
// Description : One adder89 shared by N_REQ requesters through a round-robin
//               arbiter; one registered, id-tagged result slot that can be
//               refilled every cycle the sink is ready.
//               Optional feature macro: ADDSHARE_GRANT_CNT_EN enables the
//               16-bit accepted-request counter on grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module add_share_arbiter
    import addshare_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    add_share_arbiter_if.slave bus,
    output logic [CNT_W-1:0]  grant_cnt
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    out_state_t      r_state;
    out_state_t      w_state_nxt;
    logic            w_slot_free;
    logic            w_hs;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0] w_grant_idx;
    operand_t        w_x;
    operand_t        w_y;
    sum_t            w_sum;
    sum_t            r_sum;
    logic [ID_W-1:0] r_id;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (bus.req_valid),
        .i_enable    (w_slot_free),
        .i_advance   (w_hs),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // No grant is offered while reset is asserted.
    assign bus.req_ready = w_grant & {N_REQ{rst_n}};
    assign w_hs          = |(bus.req_valid & bus.req_ready);

    // Operand mux selects the granted requester for the single adder.
    assign w_x = bus.req_x[w_grant_idx];
    assign w_y = bus.req_y[w_grant_idx];

    adder89 u_add (
        .i_a   (w_x),
        .i_b   (w_y),
        .o_sum (w_sum)
    );

    // Output slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new acceptance always fills the slot; otherwise it drains when read.
    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            w_state_nxt = FULL;
        end else if (r_state == FULL && !bus.res_ready) begin
            w_state_nxt = FULL;
        end else begin
            w_state_nxt = EMPTY;
        end
    end

    // Slot is free when empty or being read this cycle.
    always_comb begin
        bus.res_valid = (r_state == FULL);
        w_slot_free   = (r_state == EMPTY) | bus.res_ready;
    end

    // Result register captures sum and id only on acceptance; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_id  <= '0;
        end else if (w_hs) begin
            r_sum <= w_sum;
            r_id  <= w_grant_idx;
        end
    end

    assign bus.res_sum = r_sum;
    assign bus.res_id  = r_id;

`ifdef ADDSHARE_GRANT_CNT_EN
    logic [CNT_W-1:0] r_grant_cnt;

    // Free-running count of accepted requests, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else if (w_hs) begin
            r_grant_cnt <= r_grant_cnt + 1'b1;
        end
    end

    assign grant_cnt = r_grant_cnt;
`else
    assign grant_cnt = '0;
`endif

endmodule : add_share_arbiter
`default_nettype wire
